// File: rtl/avg_sample_feeder_pkg.sv
// Shared types and helpers for the averaging-stage sample feeder.
package avg_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } feeder_state_t;

    localparam int WINDOW_DEFAULT = 6;

    // Width of a counter that indexes beats 0..window-1 (at least one bit).
    function automatic int beat_cnt_width(input int window);
        if (window <= 1) begin
            return 1;
        end else begin
            return $clog2(window);
        end
    endfunction

endpackage

// File: rtl/avg_sample_feeder_if.sv
// Sample-in / beat-out bundle between the upstream source, the feeder and the averager.
interface avg_sample_feeder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_first;
    logic             out_last;

    // Upstream source / observer side.
    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_data, out_first, out_last
    );

    // Feeder side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_data, out_first, out_last
    );
endinterface

// File: rtl/avg_sample_feeder_sync_fifo.sv
// Single-clock FIFO with an occupancy counter and a registered read port.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full/empty come from the registered count, so a refused push stays refused
    // even when a pop happens in the same cycle.
    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == {LW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign level     = level_r;
    assign pop_data  = rd_data_r;

    // Storage array; contents are don't-care after reset because the pointers flush it.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= {LW{1'b0}};
            rd_data_r <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r  <= rd_ptr_r + AW'(1);
                rd_data_r <= mem_r[rd_ptr_r];
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/avg_sample_feeder.sv
// Feeder for the averaging stage: buffers bursty samples and releases them as
// WINDOW back-to-back beats only once a whole window is stored, since the
// averager cannot stall. Define AVG_FEEDER_STATS_EN to add the frame_count port.
module avg_sample_feeder
    import avg_feeder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int WINDOW = WINDOW_DEFAULT,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    avg_sample_feeder_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef AVG_FEEDER_STATS_EN
    ,
    output logic [15:0]                frame_count
`endif
);
    localparam int LW    = $clog2(DEPTH+1);
    localparam int CNT_W = beat_cnt_width(WINDOW);

    feeder_state_t    state_r;
    feeder_state_t    state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             pop_s;
    logic             push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LW-1:0]    level_s;
    logic [WIDTH-1:0] fifo_data_s;
    logic             out_valid_r;
    logic             out_first_r;
    logic             out_last_r;

    assign push_s       = bus.in_valid && !fifo_full_s;
    assign bus.in_ready = !fifo_full_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_first = out_first_r;
    assign bus.out_last  = out_last_r;
    // The FIFO read register is the beat data register: it only moves on a pop,
    // so out_data holds its last value between frames.
    assign bus.out_data  = fifo_data_s;
    assign level         = level_s;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (bus.in_data),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (level_s)
    );

    // Frame sequencer: IDLE waits for a full window, BURST pops one entry per cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (level_s >= LW'(WINDOW)) begin
                    state_nxt_s = BURST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                pop_s = !fifo_empty_s;
                if (cnt_r == CNT_W'(WINDOW - 1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = BURST;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Beat qualifiers, registered alongside the popped data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= pop_s;
            out_first_r <= pop_s && (cnt_r == {CNT_W{1'b0}});
            out_last_r  <= pop_s && (cnt_r == CNT_W'(WINDOW - 1));
        end
    end

`ifdef AVG_FEEDER_STATS_EN
    logic [15:0] frame_cnt_r;

    assign frame_count = frame_cnt_r;

    // Count frames as their last beat is launched; wraps at 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (pop_s && (cnt_r == CNT_W'(WINDOW - 1))) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end
`else
    // Statistics disabled: no frame counter.
`endif

endmodule

// File: tb/tb_avg_sample_feeder.sv
// Directed self-checking bench for avg_sample_feeder (WIDTH=32, WINDOW=6, DEPTH=16).
module tb_avg_sample_feeder;

    localparam int WIDTH  = 32;
    localparam int WINDOW = 6;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  level;
`ifdef AVG_FEEDER_STATS_EN
    logic [15:0] frame_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] q_data  [$];
    int          q_cyc   [$];
    logic        q_first [$];
    logic        q_last  [$];

    avg_sample_feeder_if #(.WIDTH(WIDTH)) bus ();

    avg_sample_feeder #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .level       (level)
`ifdef AVG_FEEDER_STATS_EN
        ,
        .frame_count (frame_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            q_data.push_back(bus.out_data);
            q_cyc.push_back(cyc);
            q_first.push_back(bus.out_first);
            q_last.push_back(bus.out_last);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_cyc.delete();
        q_first.delete();
        q_last.delete();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.out_first !== 1'b0) begin n_fail++; $display("FAIL reset_out_first got %b exp 0", bus.out_first); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
        n_checks++; if (bus.out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %0d exp 0", bus.out_data); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int sum;
        sum = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(2 * (i + 1));
            step();
        end
        bus.in_valid = 1'b0;
        n_checks++; if (level !== 5'd6) begin n_fail++; $display("FAIL basic_level6 got %0d exp 6", level); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat_t0 got %b exp 0", bus.out_valid); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat_t1 got %b exp 0", bus.out_valid); end
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid beat %0d got %b exp 1", k, bus.out_valid); end
            n_checks++; if (bus.out_data !== 32'(2 * (k + 1))) begin n_fail++; $display("FAIL basic_data beat %0d got %0d exp %0d", k, bus.out_data, 2 * (k + 1)); end
            n_checks++; if (bus.out_first !== (k == 0)) begin n_fail++; $display("FAIL basic_first beat %0d got %b exp %b", k, bus.out_first, (k == 0)); end
            n_checks++; if (bus.out_last !== (k == 5)) begin n_fail++; $display("FAIL basic_last beat %0d got %b exp %b", k, bus.out_last, (k == 5)); end
            sum += int'(bus.out_data);
        end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'd12) begin n_fail++; $display("FAIL basic_hold_data got %0d exp 12", bus.out_data); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL basic_level_end got %0d exp 0", level); end
        n_checks++; if (sum / 6 !== 7) begin n_fail++; $display("FAIL basic_avg got %0d exp 7", sum / 6); end
    endtask

    task automatic test_partial();
        push_seq(32'd100, 5);
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_idle cycle %0d got %b exp 0", i, bus.out_valid); end
        end
        n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL partial_level got %0d exp 5", level); end
        push_seq(32'd105, 1);
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_lat_t1 got %b exp 0", bus.out_valid); end
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL partial_valid beat %0d got %b exp 1", k, bus.out_valid); end
            n_checks++; if (bus.out_data !== 32'(100 + k)) begin n_fail++; $display("FAIL partial_data beat %0d got %0d exp %0d", k, bus.out_data, 100 + k); end
            n_checks++; if (bus.out_first !== (k == 0)) begin n_fail++; $display("FAIL partial_first beat %0d got %b", k, bus.out_first); end
            n_checks++; if (bus.out_last !== (k == 5)) begin n_fail++; $display("FAIL partial_last beat %0d got %b", k, bus.out_last); end
        end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_end_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int k;
        clear_mon();
        push_seq(32'd200, 12);
        k = 0;
        while (q_data.size() < 12 && k < 40) begin
            step();
            k++;
        end
        step(); step();
        n_checks++; if (q_data.size() != 12) begin n_fail++; $display("FAIL b2b_beat_count got %0d exp 12", q_data.size()); end
        if (q_data.size() >= 12) begin
            for (int i = 0; i < 12; i++) begin
                n_checks++; if (q_data[i] !== 32'(200 + i)) begin n_fail++; $display("FAIL b2b_data beat %0d got %0d exp %0d", i, q_data[i], 200 + i); end
                n_checks++; if (q_first[i] !== (i == 0 || i == 6)) begin n_fail++; $display("FAIL b2b_first beat %0d got %b", i, q_first[i]); end
                n_checks++; if (q_last[i] !== (i == 5 || i == 11)) begin n_fail++; $display("FAIL b2b_last beat %0d got %b", i, q_last[i]); end
            end
            n_checks++; if (q_cyc[5] - q_cyc[0] != 5) begin n_fail++; $display("FAIL b2b_frame0_span got %0d exp 5", q_cyc[5] - q_cyc[0]); end
            n_checks++; if (q_cyc[11] - q_cyc[6] != 5) begin n_fail++; $display("FAIL b2b_frame1_span got %0d exp 5", q_cyc[11] - q_cyc[6]); end
            n_checks++; if (q_cyc[6] - q_cyc[5] != 2) begin n_fail++; $display("FAIL b2b_gap got %0d exp 2", q_cyc[6] - q_cyc[5]); end
        end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL b2b_level got %0d exp 0", level); end
    endtask

    task automatic test_stream();
        logic [31:0] ctr;
        logic        acc_now;
        logic        saw_full;
        int          total;
        clear_mon();
        ctr      = 32'd1000;
        saw_full = 1'b0;
        for (int c = 0; c < 200; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ctr;
            acc_now      = bus.in_ready;
            n_checks++; if (bus.in_ready !== (level != 5'd16)) begin n_fail++; $display("FAIL stream_ready cycle %0d got %b level %0d", c, bus.in_ready, level); end
            if (level == 5'd16) saw_full = 1'b1;
            step();
            if (acc_now) ctr = ctr + 32'd1;
        end
        bus.in_valid = 1'b0;
        repeat (60) step();
        total = int'(ctr) - 1000;
        n_checks++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL stream_saw_full got %b exp 1", saw_full); end
        n_checks++; if (q_data.size() != total - (total % 6)) begin n_fail++; $display("FAIL stream_beats got %0d exp %0d", q_data.size(), total - (total % 6)); end
        n_checks++; if (level !== 5'(total % 6)) begin n_fail++; $display("FAIL stream_level got %0d exp %0d", level, total % 6); end
        for (int i = 0; i < q_data.size(); i++) begin
            n_checks++; if (q_data[i] !== 32'(1000 + i)) begin n_fail++; $display("FAIL stream_seq beat %0d got %0d exp %0d", i, q_data[i], 1000 + i); end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL rstmid_flush_level got %0d exp 0", level); end
        push_seq(32'd300, 6);
        k = 0;
        while (!(bus.out_valid === 1'b1 && bus.out_first === 1'b1) && k < 20) begin
            step();
            k++;
        end
        n_checks++; if (bus.out_first !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_timeout got %b exp 1", bus.out_first); end
        step(); step(); step();
        n_checks++; if (bus.out_data !== 32'd303) begin n_fail++; $display("FAIL rstmid_beat3 got %0d exp 303", bus.out_data); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL rstmid_level got %0d exp 0", level); end
        n_checks++; if (bus.out_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_data got %0d exp 0", bus.out_data); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_valid got %b exp 0", bus.out_valid); end
        push_seq(32'd400, 6);
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        n_checks++; if (bus.out_first !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_first got %b exp 1", bus.out_first); end
        n_checks++; if (bus.out_data !== 32'd400) begin n_fail++; $display("FAIL rstmid_fresh_data got %0d exp 400", bus.out_data); end
        repeat (5) step();
        n_checks++; if (bus.out_last !== 1'b1 || bus.out_data !== 32'd405) begin n_fail++; $display("FAIL rstmid_fresh_last got last %b data %0d exp 1/405", bus.out_last, bus.out_data); end
        step();
    endtask

    task automatic test_stats();
`ifdef AVG_FEEDER_STATS_EN
        do_reset();
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL stats_init got %0d exp 0", frame_count); end
        push_seq(32'd500, 18);
        repeat (40) step();
        n_checks++; if (frame_count !== 16'd3) begin n_fail++; $display("FAIL stats_three got %0d exp 3", frame_count); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL stats_level got %0d exp 0", level); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL stats_clear got %0d exp 0", frame_count); end
`else
        step();
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        test_reset();
        test_basic();
        test_partial();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
